prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Memory-side responder for the 8-bit processor's instruction/data bus. The processor drives Address; this block returns Data combinationally, with no wait states.
- Before the processor runs, a byte-stream loader fills the array through a valid/ready handshake.
- The processor is held in reset (cpu_rst_n low) until loading completes.
- Replaces the testbench's $readmemh-initialised array with synthesizable RTL.

Parameters:
- DEPTH, 24: number of 8-bit locations; range 2..256.
- FILL_BYTE, 8'h00: value returned for unwritten or out-of-range locations, and for all addresses while loading.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- Address  in  8  processor fetch/read address.
- Data  out  8  combinational read data to the processor.
- ld_valid  in  1  loader byte present.
- ld_ready  out  1  block accepts a loader byte this cycle.
- ld_byte  in  8  loader data.
- ld_last  in  1  marks the final loader byte.
- ld_restart  in  1  single-cycle request to reload; also re-holds the CPU in reset.
- cpu_rst_n  out  1  active-low reset to the Processor.
- load_count  out  8  number of bytes written in the current load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, wr_ptr=0, load_count=0, all per-location valid bits=0.
  - cpu_rst_n=0, ld_ready=0 during reset.
  - Array contents are not reset.
- States are LOAD, RELEASE and RUN.
- LOAD:
  - ld_ready=1 and cpu_rst_n=0; Data=FILL_BYTE regardless of Address.
  - Transfer occurs when ld_valid & ld_ready at a rising edge. On transfer: mem[wr_ptr]<=ld_byte, valid[wr_ptr]<=1, wr_ptr++, load_count++.
  - Go to RELEASE on a transfer with ld_last=1, or on a transfer with wr_ptr==DEPTH-1 (array full; implicit last).
  - Never wraps; no byte is accepted after full.
- RELEASE:
  - Lasts exactly one cycle; ld_ready=0, cpu_rst_n=0.
  - Always advances to RUN. This guarantees the CPU sees reset deasserted on a clean edge after the last write.
- RUN:
  - cpu_rst_n=1, ld_ready=0.
  - Data=mem[Address] if Address<DEPTH and valid[Address]=1; otherwise FILL_BYTE.
  - Data is purely combinational from Address: zero-cycle latency, matching the Processor's fetch timing.
- ld_restart=1 in any state:
  - Next state is LOAD, with wr_ptr, load_count and all valid bits cleared.
  - cpu_rst_n goes low at the same edge.
  - Restart has priority over a simultaneous transfer; that byte is not written.
- ld_valid in RELEASE/RUN: ignored, no write.
- Async reset mid-load: returns to LOAD at once; partial contents are invalidated.
- load_count saturates at DEPTH; it holds its value through RUN.

Optional Feature:
- Macro ADDR_RANGE_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - In RUN, addr_err is set at the rising edge where Address>=DEPTH or valid[Address]=0.
  - Sticky until rst or ld_restart.
- Undefined:
  - Port absent; no checking logic.
- Data behaviour is identical in both cases.

Decomposition:
- Package prog_mem_pkg:
  - state enum (LOAD, RELEASE, RUN).
  - Default FILL_BYTE constant.
  - ADDR_W=8 localparam.
- Sub-module prog_mem_array: DEPTH x 8 storage, valid bitmap with synchronous write and bulk clear, and combinational read with fill substitution. The top holds the FSM and handshake.

Test Plan:
- Hold rst=0 for 3 time units, then release. -> cpu_rst_n=0, ld_ready=1, Data=8'h00 for any Address, load_count=0.
- Stream 5 bytes A0..A4 with ld_last on A4. -> RELEASE for one cycle, then cpu_rst_n=1; Address=3 gives Data=A3; Address=7 gives 8'h00; load_count=5.
- Stream 24 bytes with no ld_last. -> Transition after byte 24 (implicit last); ld_ready=0; a 25th ld_valid is not written; Address=23 returns the 24th byte.
- In RUN, pulse ld_restart coincident with ld_valid=1, ld_byte=8'hFF. -> cpu_rst_n=0 next edge; state LOAD; load_count=0; Address=0 gives 8'h00; 8'hFF not stored.
- Assert rst=0 after 2 of 4 bytes loaded. -> Immediate LOAD, cpu_rst_n=0; after release, Data=8'h00 at addresses 0,1 until reloaded.
- With ADDR_RANGE_CHECK_EN, load 4 bytes, run, and drive Address=8'h10. -> addr_err=1 next edge and stays 1 after Address returns to 0, until ld_restart.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory responder.
// Optional feature macro: ADDR_RANGE_CHECK_EN (adds sticky addr_err output).
package prog_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] FILL_BYTE_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x 8 storage with per-location valid bitmap and fill-substituting read.
// Optional feature macro: ADDR_RANGE_CHECK_EN (exports the read hit flag).
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned        DEPTH     = 24,
  parameter logic [DATA_W-1:0]  FILL_BYTE = FILL_BYTE_DEFAULT,
  parameter int unsigned        IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef ADDR_RANGE_CHECK_EN
  output logic              rd_hit_c,
`endif
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic              in_range_c;
  logic              hit_c;
  logic [IDX_W-1:0]  rd_idx;

  // Storage write; contents deliberately not reset, validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Valid bitmap next state: bulk clear wins over a write.
  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  // Valid bitmap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Combinational read with fill substitution for misses and non-run states.
  always_comb begin
    in_range_c = CMP_W'(rd_addr) < DEPTH_CMP;
    rd_idx     = IDX_W'(rd_addr);
    hit_c      = in_range_c && valid_q[rd_idx];
    rd_data_c  = FILL_BYTE;
    if (rd_en && hit_c) rd_data_c = mem_q[rd_idx];
  end

`ifdef ADDR_RANGE_CHECK_EN
  assign rd_hit_c = hit_c;
`endif

endmodule

// File: rtl/prog_mem_responder.sv
// Program memory responder: loader handshake FSM, CPU reset hold, zero-latency read.
// Optional feature macro: ADDR_RANGE_CHECK_EN (adds sticky addr_err output).
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int unsigned       DEPTH     = 24,
  parameter logic [DATA_W-1:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_byte,
  input  logic              ld_last,
  input  logic              ld_restart,
  output logic              cpu_rst_n,
`ifdef ADDR_RANGE_CHECK_EN
  output logic              addr_err,
`endif
  output logic [7:0]        load_count
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam int unsigned      PTR_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [7:0]       CNT_MAX  = (DEPTH > 255) ? 8'hFF : 8'(DEPTH);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       count_q, count_d;
  logic             ld_ready_q, ld_ready_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             transfer_c;
  logic             wr_en_c;
  logic             clr_c;
  logic             rd_en_c;
`ifdef ADDR_RANGE_CHECK_EN
  logic             addr_err_q, addr_err_d;
  logic             rd_hit_c;
`endif

  // Next-state, pointer/count update and handshake decode; restart overrides all.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wr_en_c     = 1'b0;
    clr_c       = 1'b0;
    transfer_c  = ld_valid && ld_ready_q && (state_q == LOAD);
    rd_en_c     = (state_q == RUN);
`ifdef ADDR_RANGE_CHECK_EN
    addr_err_d  = addr_err_q | (rd_en_c & ~rd_hit_c);
`endif

    case (state_q)
      LOAD: begin
        if (transfer_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (count_q != CNT_MAX) count_d = count_q + 8'd1;
          if (ld_last || (wr_ptr_q == LAST_PTR)) state_d = RELEASE;
        end
      end
      RELEASE: state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase

    if (ld_restart) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
      count_d  = '0;
      wr_en_c  = 1'b0;
      clr_c    = 1'b1;
`ifdef ADDR_RANGE_CHECK_EN
      addr_err_d = 1'b0;
`endif
    end

    ld_ready_d  = (state_d == LOAD);
    cpu_rst_n_d = (state_d == RUN);
  end

  // State, pointer and registered handshake/reset outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ld_ready_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ld_ready_q  <= ld_ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef ADDR_RANGE_CHECK_EN
      addr_err_q  <= addr_err_d;
`endif
    end
  end

  prog_mem_array #(
    .DEPTH     (DEPTH),
    .FILL_BYTE (FILL_BYTE),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en     (wr_en_c),
    .wr_addr   (IDX_W'(wr_ptr_q)),
    .wr_data   (ld_byte),
    .clr       (clr_c),
    .rd_en     (rd_en_c),
    .rd_addr   (Address),
`ifdef ADDR_RANGE_CHECK_EN
    .rd_hit_c  (rd_hit_c),
`endif
    .rd_data_c (Data)
  );

  assign ld_ready   = ld_ready_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_count = count_q;
`ifdef ADDR_RANGE_CHECK_EN
  assign addr_err   = addr_err_q;
`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder (default DEPTH=24, FILL_BYTE=8'h00).
// Optional feature macro: ADDR_RANGE_CHECK_EN (enables addr_err checks).
module tb_prog_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Address;
  logic [7:0] Data;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_byte;
  logic       ld_last;
  logic       ld_restart;
  logic       cpu_rst_n;
  logic [7:0] load_count;
`ifdef ADDR_RANGE_CHECK_EN
  logic       addr_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prog_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .Address    (Address),
    .Data       (Data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_restart (ld_restart),
    .cpu_rst_n  (cpu_rst_n),
`ifdef ADDR_RANGE_CHECK_EN
    .addr_err   (addr_err),
`endif
    .load_count (load_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    Address = a;
    #1;
    chk(tag, Data, exp);
  endtask

  initial begin
    rst = 1'b0; Address = 8'd5; ld_valid = 1'b0; ld_byte = 8'h00;
    ld_last = 1'b0; ld_restart = 1'b0;

    // Reset held
    #2;
    chk("rst_cpu_rst_n", 8'(cpu_rst_n), 8'h0);
    chk("rst_ld_ready",  8'(ld_ready),  8'h0);
    chk("rst_count",     load_count,    8'h00);
    #1 rst = 1'b1;
    step();
    chk("load_ld_ready",  8'(ld_ready),  8'h1);
    chk("load_cpu_rst_n", 8'(cpu_rst_n), 8'h0);
    chk("load_count0",    load_count,    8'h00);
    read_chk("load_data_a5",  8'd5,   8'h00);
    read_chk("load_data_a0",  8'd0,   8'h00);
`ifdef ADDR_RANGE_CHECK_EN
    chk("load_addr_err", 8'(addr_err), 8'h0);
`endif

    // Five bytes with explicit last
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), (i == 4));
    chk("rel_cpu_rst_n", 8'(cpu_rst_n), 8'h0);
    chk("rel_ld_ready",  8'(ld_ready),  8'h0);
    step();
    chk("run_cpu_rst_n", 8'(cpu_rst_n), 8'h1);
    chk("run_ld_ready",  8'(ld_ready),  8'h0);
    chk("run_count5",    load_count,    8'h05);
    read_chk("run_a3",   8'd3,   8'hA3);
    read_chk("run_a0",   8'd0,   8'hA0);
    read_chk("run_a4",   8'd4,   8'hA4);
    read_chk("run_a7",   8'd7,   8'h00);
    read_chk("run_a200", 8'd200, 8'h00);

    // Loader bytes in RUN are ignored
    Address = 8'd5;
    send(8'h55, 1'b0);
    chk("run_ign_count", load_count, 8'h05);
    read_chk("run_ign_a5", 8'd5, 8'h00);
    read_chk("run_ign_a0", 8'd0, 8'hA0);

    // Restart coincident with a loader byte
    ld_restart = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF;
    step();
    ld_restart = 1'b0; ld_valid = 1'b0;
    chk("rs_cpu_rst_n", 8'(cpu_rst_n), 8'h0);
    chk("rs_ld_ready",  8'(ld_ready),  8'h1);
    chk("rs_count",     load_count,    8'h00);
    read_chk("rs_a0", 8'd0, 8'h00);

    // Full 24-byte load, implicit last; 25th byte offered through RELEASE/RUN
    for (int i = 0; i < 24; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'h10 + 8'(i);
      step();
    end
    ld_byte = 8'hEE;
    chk("full_ld_ready",  8'(ld_ready),  8'h0);
    chk("full_cpu_rst_n", 8'(cpu_rst_n), 8'h0);
    chk("full_count",     load_count,    8'd24);
    step();
    step();
    ld_valid = 1'b0;
    chk("full_run_cpu", 8'(cpu_rst_n), 8'h1);
    chk("full_count2",  load_count,    8'd24);
    read_chk("full_a23", 8'd23, 8'h27);
    read_chk("full_a0",  8'd0,  8'h10);
    read_chk("full_a12", 8'd12, 8'h1C);
    read_chk("full_a24", 8'd24, 8'h00);

    // Async reset in the middle of a reload
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    chk("mid_count2", load_count, 8'h02);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cpu",   8'(cpu_rst_n), 8'h0);
    chk("mid_rst_ready", 8'(ld_ready),  8'h0);
    chk("mid_rst_count", load_count,    8'h00);
    #1 rst = 1'b1;
    Address = 8'd0;
    step();
    chk("mid_ld_ready", 8'(ld_ready), 8'h1);
    read_chk("mid_a0", 8'd0, 8'h00);
    read_chk("mid_a1", 8'd1, 8'h00);
`ifdef ADDR_RANGE_CHECK_EN
    chk("mid_addr_err", 8'(addr_err), 8'h0);
`endif

    // Reload four bytes and check run contents
    Address = 8'd0;
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), (i == 3));
    step();
    chk("re_cpu_rst_n", 8'(cpu_rst_n), 8'h1);
    chk("re_count",     load_count,    8'h04);
    read_chk("re_a0", 8'd0, 8'h41);
    read_chk("re_a1", 8'd1, 8'h42);
    read_chk("re_a3", 8'd3, 8'h44);
    read_chk("re_a4", 8'd4, 8'h00);
    Address = 8'd0;

`ifdef ADDR_RANGE_CHECK_EN
    // Sticky out-of-range flag
    step();
    chk("ae_clean", 8'(addr_err), 8'h0);
    Address = 8'h10;
    step();
    chk("ae_set", 8'(addr_err), 8'h1);
    Address = 8'h00;
    step();
    chk("ae_sticky", 8'(addr_err), 8'h1);
    step();
    chk("ae_sticky2", 8'(addr_err), 8'h1);
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    chk("ae_clr", 8'(addr_err), 8'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
